rf_wb_ctrl: RTL and testbench
=============================

// Module: rf_wb_ctrl
// PURPOSE
//  Writeback controller that drives both write ports (port a, port b) of the dual-issue register file.
//  It merges three result sources: in-order lane A and lane B, plus a multi-cycle unit (LU: load/mul).
//  LU results are queued in a small FIFO and drain into whichever write port is idle.
//  It resolves same-destination conflicts and r0 writes, and registers all port outputs.
//  Outputs are registered on posedge, so they are stable before the file's negedge write.
// PARAMETERS
//  DEPTH   4        LU pending-queue entries (power of two, >=2)
//  CNT_W   3        occupancy width, $clog2(DEPTH)+1
// PORTS
//  clk        in   1         system clock, posedge
//  rst_n      in   1         asynchronous active-low reset
//  wa_valid   in   1         lane A result valid (older of the issue pair)
//  wa_rd      in   `REG_W    lane A destination
//  wa_data    in   `DATA_W   lane A result
//  wb_valid   in   1         lane B result valid (younger of the pair)
//  wb_rd      in   `REG_W    lane B destination
//  wb_data    in   `DATA_W   lane B result
//  lu_valid   in   1         LU result offered
//  lu_rd      in   `REG_W    LU destination
//  lu_data    in   `DATA_W   LU result
//  lu_ready   out  1         queue can accept; =(count<DEPTH), combinational from count reg
//  a3_a/wd3_a/we3_a   out  `REG_W/`DATA_W/1   register file write port a
//  a3_b/wd3_b/we3_b   out  `REG_W/`DATA_W/1   register file write port b
//  q_count    out  CNT_W     current queue occupancy
// BEHAVIOUR
//  Reset (async, rst_n=0): we3_a=we3_b=0, a3_*=0, wd3_*=0, queue empty, q_count=0, lu_ready=1.
//  Lane qualification:
//   - A lane is effective iff valid && rd!=0.
//   - If both lanes are effective and wa_rd==wb_rd, lane A is suppressed (B is younger and wins).
//  Port assignment, per cycle; result registered at the next posedge (lane latency = 1 cycle):
//   - Effective lane A -> port a. Effective lane B -> port b.
//   - If port a is free, the queue head drains to port a.
//   - If port b is free, the next queue entry drains to port b.
//   - Two entries may drain in one cycle, always in FIFO order.
//   - The head always takes the lower-lettered free port.
//  Ordering on drain: if both draining queue entries share an rd, the older entry is dropped.
//  Supersede rule:
//   - Any queued entry whose rd matches an effective lane rd in the same cycle is invalidated.
//   - Invalidated entries are popped without writing; a lane write is always younger.
//   - A queue entry never writes in the same cycle as a lane write to the same rd.
//  Enqueue:
//   - On lu_valid && lu_ready, and only if lu_rd!=0, push {rd,data}.
//   - lu_rd==0 is accepted and discarded.
//   - Enqueue and drain may happen in the same cycle.
//   - Full queue with 2 drains: lu_ready stays 0 this cycle; lu_ready is not a function of drains.
//   - LU minimum latency = 2 cycles: enqueue at edge N, port write visible after edge N+1.
//   - A new LU entry never bypasses the queue.
//  count_next = count + push - pops; pops counts invalidated entries too. Pointers wrap mod DEPTH.
//  lu_valid while !lu_ready: the source must hold its data; there is no drop and no error.
//  Idle ports drive we3_*=0; a3/wd3 hold their previous values.
// STRUCTURE
//  - `REG_W, `DATA_W and `REG come from def.h.
//  - Add `WB_DEPTH to def.h as the default for DEPTH.
//  - One sub-module, wb_fifo: DEPTH x {REG_W,DATA_W} circular buffer.
//    - Provides valid bits, 2-entry head peek, pop 0/1/2, and per-entry kill by rd match.
//  - Top level holds the lane qualification, port mux and output registers.
// TESTING
//  1. Reset mid-traffic: assert rst_n=0 with a full queue -> we3_a=we3_b=0 at once, q_count=0, lu_ready=1.
//  2. Lane A r5=0x11, lane B r5=0x22 in the same cycle -> next cycle we3_a=0, we3_b=1, a3_b=5, wd3_b=0x22.
//  3. Lane A rd=0, data=0xFF -> we3_a=0; one queued LU r7=0x33 drains to port a the next cycle.
//  4. Fill 4 LU entries with both lanes busy -> lu_ready=0 and q_count=4.
//     Then lanes go idle -> two entries drain per cycle in FIFO order; lu_ready=1 after the first drain edge.
//  5. Queue holds r9=0x44; lane B writes r9=0x55 -> r9 is written only with 0x55; q_count decrements by 1.
//  6. Enqueue LU r3=0xAB with empty queue, lanes idle -> we3_a=1, a3_a=3, wd3_a=0xAB exactly 2 edges after lu_valid.

Source files
------------

// File: rtl/rf_wb_ctrl_pkg.sv
// Shared widths, queue entry type and drain-port encoding for the register-file writeback controller.
package rf_wb_ctrl_pkg;

  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int WB_DEPTH = 4;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_A    = 2'd1,
    PORT_B    = 2'd2
  } wb_port_e;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_ent_t;

  function automatic logic rd_hit(input logic en, input logic [REG_W-1:0] a,
                                  input logic [REG_W-1:0] b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/rf_wb_ctrl_fifo.sv
// Pending-LU circular buffer: two-entry head peek, pop of 0/1/2 entries, and per-entry
// invalidation of any slot whose rd matches a lane write in the current cycle.
module rf_wb_ctrl_fifo
  import rf_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  wb_ent_t          i_push_ent,
  input  logic [1:0]       i_pop,
  input  logic             i_kill_a_en,
  input  logic [REG_W-1:0] i_kill_a_rd,
  input  logic             i_kill_b_en,
  input  logic [REG_W-1:0] i_kill_b_rd,
  output wb_ent_t          o_head0,
  output wb_ent_t          o_head1,
  output logic             o_head0_occ,
  output logic             o_head1_occ,
  output logic             o_head0_live,
  output logic             o_head1_live,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_ent_t          r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_rd_ptr1;
  logic [DEPTH-1:0] w_kill;
  logic [DEPTH-1:0] w_vld_nxt;

  assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_kill[i] = rd_hit(i_kill_a_en, r_mem[i].rd, i_kill_a_rd) ||
                  rd_hit(i_kill_b_en, r_mem[i].rd, i_kill_b_rd);
    end
  end

  // A slot being pushed is not yet queued, so a same-cycle kill never touches it.
  always_comb begin
    w_vld_nxt = r_vld & ~w_kill;
    if (i_push) w_vld_nxt[r_wr_ptr] = 1'b1;
  end

  assign o_head0      = r_mem[r_rd_ptr];
  assign o_head1      = r_mem[w_rd_ptr1];
  assign o_head0_occ  = (r_count != '0);
  assign o_head1_occ  = (r_count > CNT_W'(1));
  assign o_head0_live = o_head0_occ && r_vld[r_rd_ptr]  && !w_kill[r_rd_ptr];
  assign o_head1_live = o_head1_occ && r_vld[w_rd_ptr1] && !w_kill[w_rd_ptr1];
  assign o_count      = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_vld    <= w_vld_nxt;
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
      r_wr_ptr <= r_wr_ptr + PTR_W'(i_push);
      r_count  <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_ent;
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Dual-port register-file writeback controller: merges lanes A/B with queued load/mul results,
// resolves same-rd conflicts and r0 writes, and registers both write ports.
module rf_wb_ctrl
  import rf_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wa_valid,
  input  logic [REG_W-1:0]  wa_rd,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_valid,
  input  logic [REG_W-1:0]  lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic [REG_W-1:0]  a3_a,
  output logic [DATA_W-1:0] wd3_a,
  output logic              we3_a,
  output logic [REG_W-1:0]  a3_b,
  output logic [DATA_W-1:0] wd3_b,
  output logic              we3_b,
  output logic [CNT_W-1:0]  q_count
);

  logic             w_eff_a;
  logic             w_eff_b;
  logic             w_push;
  logic [1:0]       w_pop;
  logic             w_pop0;
  logic             w_pop1;
  wb_port_e         w_h0_port;
  wb_port_e         w_h1_port;
  wb_ent_t          w_h0;
  wb_ent_t          w_h1;
  logic             w_h0_occ;
  logic             w_h1_occ;
  logic             w_h0_live;
  logic             w_h1_live;
  logic [CNT_W-1:0] w_count;

  logic              w_we_a;
  logic [REG_W-1:0]  w_a3_a;
  logic [DATA_W-1:0] w_wd_a;
  logic              w_we_b;
  logic [REG_W-1:0]  w_a3_b;
  logic [DATA_W-1:0] w_wd_b;

  // B is the younger of the issue pair, so it wins a same-rd collision with A.
  assign w_eff_b = wb_valid && (wb_rd != '0);
  assign w_eff_a = wa_valid && (wa_rd != '0) && !(w_eff_b && (wa_rd == wb_rd));

  assign lu_ready = (w_count < CNT_W'(DEPTH));
  assign w_push   = lu_valid && lu_ready && (lu_rd != '0);
  assign q_count  = w_count;

  rf_wb_ctrl_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_ent   ('{rd: lu_rd, data: lu_data}),
    .i_pop        (w_pop),
    .i_kill_a_en  (w_eff_a),
    .i_kill_a_rd  (wa_rd),
    .i_kill_b_en  (w_eff_b),
    .i_kill_b_rd  (wb_rd),
    .o_head0      (w_h0),
    .o_head1      (w_h1),
    .o_head0_occ  (w_h0_occ),
    .o_head1_occ  (w_h1_occ),
    .o_head0_live (w_h0_live),
    .o_head1_live (w_h1_live),
    .o_count      (w_count)
  );

  // Dead entries pop without a port; live ones take the lowest free port, strictly in order.
  always_comb begin
    w_pop0    = 1'b0;
    w_pop1    = 1'b0;
    w_h0_port = PORT_NONE;
    w_h1_port = PORT_NONE;
    if (w_h0_occ) begin
      if (!w_h0_live) begin
        w_pop0 = 1'b1;
      end else if (!w_eff_a) begin
        w_pop0    = 1'b1;
        w_h0_port = PORT_A;
      end else if (!w_eff_b) begin
        w_pop0    = 1'b1;
        w_h0_port = PORT_B;
      end
    end
    if (w_pop0 && w_h1_occ) begin
      if (!w_h1_live) begin
        w_pop1 = 1'b1;
      end else if (!w_eff_a && (w_h0_port != PORT_A)) begin
        w_pop1    = 1'b1;
        w_h1_port = PORT_A;
      end else if (!w_eff_b && (w_h0_port != PORT_B)) begin
        w_pop1    = 1'b1;
        w_h1_port = PORT_B;
      end
    end
    if ((w_h0_port != PORT_NONE) && (w_h1_port != PORT_NONE) && (w_h0.rd == w_h1.rd)) begin
      w_h0_port = PORT_NONE;
    end
  end

  assign w_pop = {1'b0, w_pop0} + {1'b0, w_pop1};

  always_comb begin
    w_we_a = w_eff_a || (w_h0_port == PORT_A) || (w_h1_port == PORT_A);
    w_a3_a = w_h1.rd;
    w_wd_a = w_h1.data;
    if (w_eff_a) begin
      w_a3_a = wa_rd;
      w_wd_a = wa_data;
    end else if (w_h0_port == PORT_A) begin
      w_a3_a = w_h0.rd;
      w_wd_a = w_h0.data;
    end

    w_we_b = w_eff_b || (w_h0_port == PORT_B) || (w_h1_port == PORT_B);
    w_a3_b = w_h1.rd;
    w_wd_b = w_h1.data;
    if (w_eff_b) begin
      w_a3_b = wb_rd;
      w_wd_b = wb_data;
    end else if (w_h0_port == PORT_B) begin
      w_a3_b = w_h0.rd;
      w_wd_b = w_h0.data;
    end
  end

  // Idle ports hold address/data; only the enables drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_a <= 1'b0;
      a3_a  <= '0;
      wd3_a <= '0;
      we3_b <= 1'b0;
      a3_b  <= '0;
      wd3_b <= '0;
    end else begin
      we3_a <= w_we_a;
      we3_b <= w_we_b;
      if (w_we_a) begin
        a3_a  <= w_a3_a;
        wd3_a <= w_wd_a;
      end
      if (w_we_b) begin
        a3_b  <= w_a3_b;
        wd3_b <= w_wd_b;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_rf_wb_ctrl;
  import rf_wb_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wa_valid, wb_valid, lu_valid;
  logic [REG_W-1:0]  wa_rd, wb_rd, lu_rd;
  logic [DATA_W-1:0] wa_data, wb_data, lu_data;
  logic              lu_ready, we3_a, we3_b;
  logic [REG_W-1:0]  a3_a, a3_b;
  logic [DATA_W-1:0] wd3_a, wd3_b;
  logic [CNT_W-1:0]  q_count;

  always #5 clk = ~clk;

  rf_wb_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wa_valid(wa_valid), .wa_rd(wa_rd), .wa_data(wa_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .a3_a(a3_a), .wd3_a(wd3_a), .we3_a(we3_a),
    .a3_b(a3_b), .wd3_b(wd3_b), .we3_b(we3_b),
    .q_count(q_count)
  );

  typedef struct {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    bit                dead;
  } qent_t;

  qent_t             mq[$];
  logic              m_we_a, m_we_b;
  logic [REG_W-1:0]  m_a3_a, m_a3_b;
  logic [DATA_W-1:0] m_wd_a, m_wd_b;
  int                n_chk = 0;
  int                n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_we_a = 1'b0; m_we_b = 1'b0;
    m_a3_a = '0;   m_a3_b = '0;
    m_wd_a = '0;   m_wd_b = '0;
  endtask

  // One clock of behaviour, evaluated on the inputs present before the edge.
  task automatic model_step();
    bit    ea, eb, push;
    int    ports[$];
    int    wport[$];
    qent_t went[$];
    int    pops;
    ea = wa_valid && (wa_rd != 0);
    eb = wb_valid && (wb_rd != 0);
    if (ea && eb && (wa_rd == wb_rd)) ea = 1'b0;
    push = lu_valid && (mq.size() < DEPTH) && (lu_rd != 0);
    foreach (mq[i])
      if ((ea && mq[i].rd == wa_rd) || (eb && mq[i].rd == wb_rd)) mq[i].dead = 1'b1;
    if (!ea) ports.push_back(0);
    if (!eb) ports.push_back(1);
    pops = 0;
    while (pops < 2 && mq.size() > 0) begin
      if (mq[0].dead) begin
        void'(mq.pop_front());
        pops++;
      end else if (ports.size() == 0) begin
        break;
      end else begin
        wport.push_back(ports.pop_front());
        went.push_back(mq.pop_front());
        pops++;
      end
    end
    if (went.size() == 2 && went[0].rd == went[1].rd) begin
      void'(wport.pop_front());
      void'(went.pop_front());
    end
    m_we_a = ea;
    m_we_b = eb;
    if (ea) begin m_a3_a = wa_rd; m_wd_a = wa_data; end
    if (eb) begin m_a3_b = wb_rd; m_wd_b = wb_data; end
    foreach (went[i]) begin
      if (wport[i] == 0) begin
        m_we_a = 1'b1; m_a3_a = went[i].rd; m_wd_a = went[i].data;
      end else begin
        m_we_b = 1'b1; m_a3_b = went[i].rd; m_wd_b = went[i].data;
      end
    end
    if (push) mq.push_back('{lu_rd, lu_data, 1'b0});
  endtask

  task automatic check_outputs();
    check("we3_a",    32'(we3_a),    32'(m_we_a));
    check("a3_a",     32'(a3_a),     32'(m_a3_a));
    check("wd3_a",    wd3_a,         m_wd_a);
    check("we3_b",    32'(we3_b),    32'(m_we_b));
    check("a3_b",     32'(a3_b),     32'(m_a3_b));
    check("wd3_b",    wd3_b,         m_wd_b);
    check("q_count",  32'(q_count),  mq.size());
    check("lu_ready", 32'(lu_ready), 32'(mq.size() < DEPTH));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    wa_valid = 1'b0; wa_rd = '0; wa_data = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
  endtask

  task automatic set_a(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
    wa_valid = 1'b1; wa_rd = rd; wa_data = d;
  endtask

  task automatic set_b(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
  endtask

  task automatic set_lu(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
    lu_valid = 1'b1; lu_rd = rd; lu_data = d;
  endtask

  task automatic fill_queue_busy();
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      set_a(5'd1, 32'h1000 + 32'(i));
      set_b(5'd2, 32'h2000 + 32'(i));
      set_lu(5'(10 + i), 32'h100 + 32'(i));
      cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    check_outputs();
    rst_n = 1'b1;

    // Same-rd lane collision: B wins
    set_a(5'd5, 32'h11);
    set_b(5'd5, 32'h22);
    cycle();
    check("t2_we_a", 32'(we3_a), 0);
    check("t2_we_b", 32'(we3_b), 1);
    check("t2_a3_b", 32'(a3_b), 5);
    check("t2_wd_b", wd3_b, 32'h22);
    idle();

    // LU minimum latency of two edges
    set_lu(5'd3, 32'hAB);
    cycle();
    idle();
    check("t6_early", 32'(we3_a), 0);
    cycle();
    check("t6_we_a", 32'(we3_a), 1);
    check("t6_a3_a", 32'(a3_a), 3);
    check("t6_wd_a", wd3_a, 32'hAB);

    // r0 lane write is dropped; queued entry takes port a
    set_a(5'd0, 32'hFF);
    cycle();
    check("t3_r0", 32'(we3_a), 0);
    idle();
    set_lu(5'd7, 32'h33);
    cycle();
    idle();
    set_a(5'd0, 32'hFF);
    cycle();
    check("t3_we_a", 32'(we3_a), 1);
    check("t3_a3_a", 32'(a3_a), 7);
    check("t3_wd_a", wd3_a, 32'h33);
    idle();

    // Lane write supersedes a queued entry with the same rd
    set_a(5'd1, 32'h1);
    set_b(5'd2, 32'h2);
    set_lu(5'd9, 32'h44);
    cycle();
    check("t5_q1", 32'(q_count), 1);
    idle();
    set_b(5'd9, 32'h55);
    cycle();
    check("t5_we_a", 32'(we3_a), 0);
    check("t5_a3_b", 32'(a3_b), 9);
    check("t5_wd_b", wd3_b, 32'h55);
    check("t5_q0", 32'(q_count), 0);
    idle();

    // Full queue, then double drain in FIFO order
    fill_queue_busy();
    check("t4_full", 32'(q_count), 4);
    check("t4_rdy0", 32'(lu_ready), 0);
    cycle();
    check("t4_d1a", 32'(a3_a), 10);
    check("t4_d1b", 32'(a3_b), 11);
    check("t4_rdy1", 32'(lu_ready), 1);
    cycle();
    check("t4_d2a", 32'(a3_a), 12);
    check("t4_d2b", 32'(a3_b), 13);
    check("t4_q0", 32'(q_count), 0);

    // Asynchronous reset with a full queue
    fill_queue_busy();
    #3;
    rst_n = 1'b0;
    #1;
    check("t1_we_a", 32'(we3_a), 0);
    check("t1_we_b", 32'(we3_b), 0);
    check("t1_q", 32'(q_count), 0);
    check("t1_rdy", 32'(lu_ready), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Randomized traffic with small rd range to provoke conflicts
    for (int n = 0; n < 600; n++) begin
      wa_valid = ($urandom_range(0, 99) < 55);
      wa_rd    = 5'($urandom_range(0, 7));
      wa_data  = $urandom();
      wb_valid = ($urandom_range(0, 99) < 55);
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom();
      if (!(lu_valid && mq.size() >= DEPTH)) begin
        lu_valid = ($urandom_range(0, 99) < 60);
        lu_rd    = 5'($urandom_range(0, 7));
        lu_data  = $urandom();
      end
      cycle();
    end
    idle();
    for (int n = 0; n < 4; n++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
